// File: rtl/mw_mr_responder_if.sv
// Request/response bundle between an mw/mr initiator and the mw_mr_responder target.
// The master side is the initiator; the slave side is the responding memory.
interface mw_mr_responder_if #(
  parameter int unsigned DT_WD = 64
);
  logic                 mw_en;
  logic [DT_WD-1:0]     mw_addr;
  logic [11:0]          mw_len;
  logic                 mw_data_en;
  logic [DT_WD-1:0]     mw_data;
  logic [DT_WD/8-1:0]   mw_data_be;
  logic                 mw_op_over;

  logic                 mr_en;
  logic [DT_WD-1:0]     mr_addr;
  logic [11:0]          mr_len;
  logic [DT_WD/8-1:0]   mr_data_be;
  logic [DT_WD-1:0]     mr_data;
  logic                 mr_data_vld;
  logic                 mr_op_over;

  logic                 busy;
  logic [7:0]           drop_cnt;

  modport master (
    output mw_en, mw_addr, mw_len, mw_data, mw_data_be,
    output mr_en, mr_addr, mr_len, mr_data_be,
    input  mw_data_en, mw_op_over, mr_data, mr_data_vld, mr_op_over,
    input  busy, drop_cnt
  );

  modport slave (
    input  mw_en, mw_addr, mw_len, mw_data, mw_data_be,
    input  mr_en, mr_addr, mr_len, mr_data_be,
    output mw_data_en, mw_op_over, mr_data, mr_data_vld, mr_op_over,
    output busy, drop_cnt
  );
endinterface

// File: rtl/mw_mr_responder.sv
// Memory-write / memory-read target: pulls write beats into a word-addressed scratch
// memory, streams masked read beats back, and flags completion with a one-cycle op_over.
module mw_mr_responder #(
  parameter int unsigned DT_WD = 64,
  parameter int unsigned AW    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  mw_mr_responder_if.slave  bus
);

  localparam int unsigned BW  = DT_WD / 8;
  localparam int unsigned OFS = $clog2(BW);
  localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [11:0]   LEN_ONE = 12'd1;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_DRAIN,
    RD,
    DONE
  } state_t;

  state_t            state_q;
  logic [11:0]       cnt_q;
  logic [AW-1:0]     idx_q;
  logic [BW-1:0]     rd_be_q;
  logic              wr_vld_q;
  logic              mw_data_en_q;
  logic              mw_op_over_q;
  logic              mr_op_over_q;
  logic              mr_data_vld_q;
  logic [DT_WD-1:0]  mr_data_q;
  logic [7:0]        drop_q;
  logic [7:0]        drop_d;
  logic              drop_evt;
  logic [DT_WD-1:0]  rd_mask;

  logic [DT_WD-1:0]  mem [2**AW];

  // Only the word-index slice of each address matters.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mw_addr, bus.mr_addr};

  always_comb begin
    rd_mask = '0;
    for (int unsigned b = 0; b < BW; b++) begin
      rd_mask[b*8 +: 8] = {8{rd_be_q[b]}};
    end
  end

  // In IDLE only the read half of a simultaneous request is lost; elsewhere every request is.
  always_comb begin
    drop_evt = (state_q == IDLE) ? (bus.mw_en && bus.mr_en) : (bus.mw_en || bus.mr_en);
    drop_d   = drop_q;
    if (drop_evt && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld_q) begin
      for (int unsigned b = 0; b < BW; b++) begin
        if (bus.mw_data_be[b]) begin
          mem[idx_q][b*8 +: 8] <= bus.mw_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      rd_be_q       <= '0;
      wr_vld_q      <= 1'b0;
      mw_data_en_q  <= 1'b0;
      mw_op_over_q  <= 1'b0;
      mr_op_over_q  <= 1'b0;
      mr_data_vld_q <= 1'b0;
      mr_data_q     <= '0;
      drop_q        <= '0;
    end else begin
      drop_q        <= drop_d;
      wr_vld_q      <= mw_data_en_q;
      mw_op_over_q  <= 1'b0;
      mr_op_over_q  <= 1'b0;
      mr_data_vld_q <= 1'b0;
      if (wr_vld_q) begin
        idx_q <= idx_q + IDX_ONE;
      end

      case (state_q)
        IDLE: begin
          if (bus.mw_en) begin
            idx_q <= bus.mw_addr[OFS +: AW];
            cnt_q <= bus.mw_len;
            if (bus.mw_len == '0) begin
              state_q      <= DONE;
              mw_op_over_q <= 1'b1;
            end else begin
              state_q      <= WR_REQ;
              mw_data_en_q <= 1'b1;
            end
          end else if (bus.mr_en) begin
            idx_q   <= bus.mr_addr[OFS +: AW];
            cnt_q   <= bus.mr_len;
            rd_be_q <= bus.mr_data_be;
            if (bus.mr_len == '0) begin
              state_q      <= DONE;
              mr_op_over_q <= 1'b1;
            end else begin
              state_q <= RD;
            end
          end
        end

        WR_REQ: begin
          cnt_q <= cnt_q - LEN_ONE;
          if (cnt_q == LEN_ONE) begin
            mw_data_en_q <= 1'b0;
            state_q      <= WR_DRAIN;
          end
        end

        WR_DRAIN: begin
          state_q      <= DONE;
          mw_op_over_q <= 1'b1;
        end

        // RD keeps one tail cycle after the last read so the final beat's valid
        // is out before DONE raises mr_op_over.
        RD: begin
          if (cnt_q != '0) begin
            mr_data_q     <= mem[idx_q] & rd_mask;
            mr_data_vld_q <= 1'b1;
            idx_q         <= idx_q + IDX_ONE;
            cnt_q         <= cnt_q - LEN_ONE;
          end else begin
            state_q      <= DONE;
            mr_op_over_q <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mw_data_en  = mw_data_en_q;
  assign bus.mw_op_over  = mw_op_over_q;
  assign bus.mr_data     = mr_data_q;
  assign bus.mr_data_vld = mr_data_vld_q;
  assign bus.mr_op_over  = mr_op_over_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.drop_cnt    = drop_q;

endmodule

// File: tb/tb_mw_mr_responder.sv
// Directed bench for mw_mr_responder: burst timing, byte enables, wrap, len=0,
// request drops with saturation, and reset in the middle of a write burst.
module tb_mw_mr_responder;

  logic clk;
  logic rst_n;

  mw_mr_responder_if #(.DT_WD(64)) bus ();

  mw_mr_responder #(
    .DT_WD (64),
    .AW    (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [63:0] wbeat [16];
  logic [63:0] rbeat [16];

  int          en_cnt, en_first, wr_over, vld_seen;
  int          vld_cnt, vld_first, vld_last, rd_over;
  logic        busy_at1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one write request and plays the initiator: each beat follows its mw_data_en by a cycle.
  task automatic do_wr(input logic [63:0] addr, input int len, input logic [7:0] be,
                       input bit coll, input int rd_pulse_at, input bit rd_hold, input int rst_at);
    bit prev_en;
    int k;
    prev_en  = 1'b0;
    k        = 0;
    en_cnt   = 0;
    en_first = -1;
    wr_over  = -1;
    vld_seen = 0;
    busy_at1 = 1'b0;
    bus.mw_en      = 1'b1;
    bus.mw_addr    = addr;
    bus.mw_len     = 12'(len);
    bus.mw_data_be = be;
    bus.mr_en      = coll;
    bus.mr_addr    = 64'h0;
    bus.mr_len     = 12'd1;
    for (int c = 1; c <= len + 10; c++) begin
      tick();
      bus.mw_en = 1'b0;
      bus.mr_en = rd_hold || (c == rd_pulse_at);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_mw_data_en", 64'(bus.mw_data_en), 64'd0);
        chk("rst_mw_op_over", 64'(bus.mw_op_over), 64'd0);
        chk("rst_busy",       64'(bus.busy),       64'd0);
        chk("rst_drop_cnt",   64'(bus.drop_cnt),   64'd0);
        chk("rst_mr_vld",     64'(bus.mr_data_vld), 64'd0);
        bus.mr_en = 1'b0;
        return;
      end
      if (prev_en) begin
        bus.mw_data = wbeat[k % 16];
        k++;
      end else begin
        bus.mw_data = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      if (c == 1) busy_at1 = bus.busy;
      if (bus.mw_data_en) begin
        en_cnt++;
        if (en_first < 0) en_first = c;
      end
      prev_en = bus.mw_data_en;
      if (bus.mr_data_vld) vld_seen++;
      if (bus.mw_op_over) begin
        wr_over = c;
        break;
      end
    end
    bus.mr_en = 1'b0;
    chk("wr_op_over_seen", 64'(wr_over >= 0), 64'd1);
  endtask

  task automatic do_rd(input logic [63:0] addr, input int len, input logic [7:0] be);
    vld_cnt   = 0;
    vld_first = -1;
    vld_last  = -1;
    rd_over   = -1;
    bus.mr_en      = 1'b1;
    bus.mr_addr    = addr;
    bus.mr_len     = 12'(len);
    bus.mr_data_be = be;
    for (int c = 1; c <= len + 10; c++) begin
      tick();
      bus.mr_en = 1'b0;
      if (bus.mr_data_vld) begin
        if (vld_cnt < 16) rbeat[vld_cnt] = bus.mr_data;
        vld_cnt++;
        if (vld_first < 0) vld_first = c;
        vld_last = c;
      end
      if (bus.mr_op_over) begin
        rd_over = c;
        break;
      end
    end
    chk("rd_op_over_seen", 64'(rd_over >= 0), 64'd1);
  endtask

  int op_seen;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.mw_en = 1'b0; bus.mw_addr = '0; bus.mw_len = '0; bus.mw_data = '0; bus.mw_data_be = '0;
    bus.mr_en = 1'b0; bus.mr_addr = '0; bus.mr_len = '0; bus.mr_data_be = '0;
    repeat (3) tick();
    chk("reset_mw_data_en", 64'(bus.mw_data_en),  64'd0);
    chk("reset_mw_op_over", 64'(bus.mw_op_over),  64'd0);
    chk("reset_mr_data",    bus.mr_data,          64'd0);
    chk("reset_mr_vld",     64'(bus.mr_data_vld), 64'd0);
    chk("reset_mr_op_over", 64'(bus.mr_op_over),  64'd0);
    chk("reset_busy",       64'(bus.busy),        64'd0);
    chk("reset_drop_cnt",   64'(bus.drop_cnt),    64'd0);
    rst_n = 1'b1;
    tick();

    // Write then read back at word 32.
    wbeat[0] = 64'h1111_1111_1111_1111; wbeat[1] = 64'h2222_2222_2222_2222;
    wbeat[2] = 64'h3333_3333_3333_3333; wbeat[3] = 64'h4444_4444_4444_4444;
    do_wr(64'h100, 4, 8'hFF, 1'b0, 0, 1'b0, 0);
    chk("wr4_en_cnt",   64'(en_cnt),   64'd4);
    chk("wr4_en_first", 64'(en_first), 64'd1);
    chk("wr4_op_over",  64'(wr_over),  64'd6);
    chk("wr4_busy",     64'(busy_at1), 64'd1);
    tick();
    chk("idle_busy",    64'(bus.busy), 64'd0);
    do_rd(64'h100, 4, 8'hFF);
    chk("rd4_vld_first", 64'(vld_first), 64'd2);
    chk("rd4_vld_last",  64'(vld_last),  64'd5);
    chk("rd4_vld_cnt",   64'(vld_cnt),   64'd4);
    chk("rd4_op_over",   64'(rd_over),   64'd6);
    chk("rd4_beat0", rbeat[0], 64'h1111_1111_1111_1111);
    chk("rd4_beat1", rbeat[1], 64'h2222_2222_2222_2222);
    chk("rd4_beat2", rbeat[2], 64'h3333_3333_3333_3333);
    chk("rd4_beat3", rbeat[3], 64'h4444_4444_4444_4444);
    tick();

    // Byte enables on word 0.
    wbeat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_wr(64'h0, 1, 8'hFF, 1'b0, 0, 1'b0, 0);
    chk("wr1_op_over", 64'(wr_over), 64'd3);
    tick();
    wbeat[0] = 64'h0123_4567_89AB_CDEF;
    do_wr(64'h0, 1, 8'h0F, 1'b0, 0, 1'b0, 0);
    tick();
    do_rd(64'h0, 1, 8'hFF);
    chk("be_rd_ff", rbeat[0], 64'hFFFF_FFFF_89AB_CDEF);
    chk("rd1_op_over", 64'(rd_over), 64'd3);
    tick();
    do_rd(64'h0, 1, 8'hF0);
    chk("be_rd_f0", rbeat[0], 64'hFFFF_FFFF_0000_0000);
    tick();

    // Wrap from word 1023 to word 0.
    wbeat[0] = 64'hAAAA_0000_0000_000A; wbeat[1] = 64'hBBBB_0000_0000_000B;
    wbeat[2] = 64'hCCCC_0000_0000_000C;
    do_wr(64'h1FF8, 3, 8'hFF, 1'b0, 0, 1'b0, 0);
    tick();
    do_rd(64'h1FF8, 3, 8'hFF);
    chk("wrap_rd0", rbeat[0], 64'hAAAA_0000_0000_000A);
    chk("wrap_rd1", rbeat[1], 64'hBBBB_0000_0000_000B);
    chk("wrap_rd2", rbeat[2], 64'hCCCC_0000_0000_000C);
    tick();
    do_rd(64'h0, 2, 8'hFF);
    chk("wrap_word0", rbeat[0], 64'hBBBB_0000_0000_000B);
    chk("wrap_word1", rbeat[1], 64'hCCCC_0000_0000_000C);
    tick();
    do_rd(64'hABCD_0000_0000_2008, 1, 8'hFF);
    chk("upper_addr_ignored", rbeat[0], 64'hCCCC_0000_0000_000C);
    tick();

    // Zero-length requests.
    do_wr(64'h40, 0, 8'hFF, 1'b0, 0, 1'b0, 0);
    chk("wr0_op_over", 64'(wr_over), 64'd1);
    chk("wr0_en_cnt",  64'(en_cnt),  64'd0);
    tick();
    do_rd(64'h40, 0, 8'hFF);
    chk("rd0_op_over", 64'(rd_over), 64'd1);
    chk("rd0_vld_cnt", 64'(vld_cnt), 64'd0);
    tick();

    // Collision in IDLE, then a read during a burst, then saturation.
    wbeat[0] = 64'hD0D0_D0D0_D0D0_D0D0; wbeat[1] = 64'hD1D1_D1D1_D1D1_D1D1;
    do_wr(64'h200, 2, 8'hFF, 1'b1, 0, 1'b0, 0);
    chk("coll_op_over",  64'(wr_over),      64'd4);
    chk("coll_no_read",  64'(vld_seen),     64'd0);
    chk("coll_drop_cnt", 64'(bus.drop_cnt), 64'd1);
    tick();
    chk("coll_no_late_read", 64'(bus.mr_data_vld), 64'd0);
    do_rd(64'h200, 2, 8'hFF);
    chk("coll_wr0", rbeat[0], 64'hD0D0_D0D0_D0D0_D0D0);
    chk("coll_wr1", rbeat[1], 64'hD1D1_D1D1_D1D1_D1D1);
    tick();
    for (int i = 0; i < 4; i++) wbeat[i] = 64'hE000_0000_0000_0000 | 64'(i);
    do_wr(64'h300, 4, 8'hFF, 1'b0, 2, 1'b0, 0);
    chk("busy_drop_cnt", 64'(bus.drop_cnt), 64'd2);
    chk("busy_no_read",  64'(vld_seen),     64'd0);
    chk("busy_op_over",  64'(wr_over),      64'd6);
    tick();
    do_wr(64'h100, 300, 8'h00, 1'b0, 0, 1'b1, 0);
    chk("sat_op_over",  64'(wr_over),      64'd302);
    chk("sat_en_cnt",   64'(en_cnt),       64'd300);
    chk("sat_drop_cnt", 64'(bus.drop_cnt), 64'd255);
    tick();
    do_rd(64'h100, 1, 8'hFF);
    chk("be0_unchanged", rbeat[0], 64'h1111_1111_1111_1111);
    chk("sat_hold",      64'(bus.drop_cnt), 64'd255);
    tick();

    // Reset during beat 2 of an 8-beat write.
    wbeat[0] = 64'h0A0A_0000_0000_0000; wbeat[1] = 64'h0A0A_0000_0000_0001;
    wbeat[2] = 64'h0A0A_0000_0000_0002;
    do_wr(64'd800, 3, 8'hFF, 1'b0, 0, 1'b0, 0);
    tick();
    for (int i = 0; i < 8; i++) wbeat[i] = 64'h5050_0000_0000_0000 | 64'(i);
    do_wr(64'd800, 8, 8'hFF, 1'b0, 0, 1'b0, 4);
    op_seen = 0;
    repeat (2) begin
      tick();
      if (bus.mw_op_over) op_seen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      tick();
      if (bus.mw_op_over || bus.mw_data_en) op_seen++;
    end
    chk("rst_no_op_over", 64'(op_seen), 64'd0);
    do_rd(64'd800, 3, 8'hFF);
    chk("rst_beat0_kept", rbeat[0], 64'h5050_0000_0000_0000);
    chk("rst_beat1_kept", rbeat[1], 64'h5050_0000_0000_0001);
    chk("rst_beat2_lost", rbeat[2], 64'h0A0A_0000_0000_0002);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mw_mr_responder.md
# mw_mr_responder

Memory-write / memory-read target that services the `mw_*` and `mr_*` request interface issued by the register/data test sequencers (`ip_regrw`-style initiators). It is the responding end of that interface: it pulls write beats from the initiator, stores them in a local word-addressed memory, returns read beats with a valid strobe, and signals completion with `*_op_over`. It stands in for the RC op engine in unit-level benches, and serves as a BAR-backed scratch memory on the subsystem side.

## Interface
- `DT_WD`, 64: data beat width in bits; byte-enable width is `DT_WD/8`.
- `AW`, 10: memory depth is 2^AW words of `DT_WD` bits.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mw_en`  in  1  write request strobe; one cycle.
- `mw_addr`  in  DT_WD  byte address of the first beat.
- `mw_len`  in  12  number of beats (0 = none).
- `mw_data_en`  out  1  beat request to the initiator.
- `mw_data`  in  DT_WD  write beat.
- `mw_data_be`  in  DT_WD/8  per-byte write enable for the beat.
- `mw_op_over`  out  1  write done; one-cycle pulse.
- `mr_en`  in  1  read request strobe; one cycle.
- `mr_addr`  in  DT_WD  byte address of the first beat.
- `mr_len`  in  12  number of beats.
- `mr_data_be`  in  DT_WD/8  byte mask for every returned beat.
- `mr_data`  out  DT_WD  read beat.
- `mr_data_vld`  out  1  `mr_data` valid.
- `mr_op_over`  out  1  read done; one-cycle pulse.
- `busy`  out  1  high when the FSM is not in IDLE.
- `drop_cnt`  out  8  saturating count of dropped requests.

## Operation
- **Word index:** `addr[log2(DT_WD/8) +: AW]`. Upper address bits are ignored.
- **Wrap-around:** the index increments per beat modulo 2^AW, so a burst wraps from the last word to word 0.
- **FSM states:** IDLE, WR_REQ, WR_DRAIN, RD, DONE.
- **IDLE, `mw_en`=1:**
  - Latch `mw_addr` and `mw_len`.
  - Go to WR_REQ, or to DONE if len=0.
- **IDLE, `mr_en`=1 (and `mw_en`=0):**
  - Latch `mr_addr`, `mr_len` and `mr_data_be`.
  - Go to RD, or to DONE if len=0.
- **IDLE, `mw_en` and `mr_en` both high:** the write is accepted, the read is dropped, and `drop_cnt` increments.
- **WR_REQ:**
  - `mw_data_en`=1 for exactly len consecutive cycles.
  - Then go to WR_DRAIN for one cycle, then to DONE.
- **Write beats:**
  - The initiator presents each beat one cycle after the matching `mw_data_en` cycle.
  - The responder writes that beat to memory with byte granularity per `mw_data_be`.
  - If `mw_data_be`=0, memory is left unchanged, but the beat still counts.
- **RD:**
  - Issue len synchronous memory reads, one per cycle.
  - `mr_data_vld` follows each read by one cycle.
  - `mr_data` = memory word AND the byte mask expanded from the latched `mr_data_be`.
  - After the last read issues, go to DONE.
- **DONE:** pulse `mw_op_over` or `mr_op_over` according to the operation type, then return to IDLE.
- **Requests while busy:** any `mw_en` or `mr_en` seen outside IDLE is ignored and increments `drop_cnt`. If both are high, the increment is still 1.
- **`drop_cnt`:** saturates at 255.
- **Memory:** has no reset; contents survive `rst_n`.

## Timing
- **Reset values:** all outputs are 0 and the FSM is in IDLE.
- **Reset mid-operation:** the burst aborts immediately. No `op_over` is issued, and a write beat already in flight is discarded.
- **Write**, with `mw_en` sampled high at cycle T and len=L≥1:
  - `mw_data_en` is high for cycles T+1..T+L.
  - Beats are captured at T+2..T+L+1.
  - `mw_op_over` pulses at T+L+2.
- **Read**, with `mr_en` sampled at T and len=L≥1:
  - `mr_data_vld` is high for cycles T+2..T+L+1, back-to-back with no gaps.
  - `mr_op_over` pulses at T+L+2.
- **len=0:** `op_over` pulses at T+1, with no data strobes.
- **Next request:** the earliest next accepted request is the cycle after the `op_over` pulse.
- **Read-after-write:** a read issued after `mw_op_over` returns the newly written data. No bypass is needed because the operations are serialized.

## Test plan
- **Write then read:** write addr 0x100 (word 32), L=4, data 0x11..11, 0x22..22, 0x33..33, 0x44..44, be=0xFF.
  - `mw_data_en` is high for 4 cycles and `mw_op_over` pulses at T+6.
  - Reading the same range with be=0xFF returns the 4 words in order on `mr_data_vld` at T'+2..T'+5, and `mr_op_over` pulses at T'+6.
- **Byte enables:** preload word 0 with 0xFFFF_FFFF_FFFF_FFFF, then write 0x0123_4567_89AB_CDEF with be=0x0F.
  - Reading with be=0xFF returns 0xFFFF_FFFF_89AB_CDEF.
  - Reading with be=0xF0 returns 0xFFFF_FFFF_0000_0000.
- **Wrap:** with AW=10, write L=3 starting at word 1023 with values A, B, C.
  - Words 1023, 0 and 1 hold A, B and C.
  - Reading L=3 from word 1023 returns A, B, C.
- **len=0:** `mw_en` with L=0 gives `mw_op_over` at T+1 with no `mw_data_en`; `mr_en` with L=0 gives `mr_op_over` at T+1 with no `mr_data_vld`.
- **Collision and busy drop:**
  - `mw_en` and `mr_en` in the same idle cycle: the write completes, there is no read response, and `drop_cnt`=1.
  - `mr_en` during the write burst: ignored, `drop_cnt`=2.
  - 300 further busy drops: `drop_cnt` holds at 255.
- **Reset mid-burst:** assert `rst_n`=0 during beat 2 of an L=8 write.
  - All outputs go to 0 and no `mw_op_over` is issued.
  - A subsequent read of beat 0 returns the value written before reset.
